vend_order_ctrl: RTL and testbench

Customer-side order controller for the two-machine vending unit. It accumulates inserted coins into a credit, issues a single one-cycle purchase request (money, vm, productID, sugar) to the vending unit, and decodes the registered status response. It then returns change or a refund one coin per cycle. It sits between the coin/keypad front panel and the vending unit's request/status ports.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/change_dispenser.sv | 55 +++++
 rtl/vend_order_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_vend_order_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared coin encodings, product IDs, error codes and FSM states
// for the vending-unit order controller.
package vend_pkg;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;
    localparam logic [1:0] COIN_20 = 2'b11;

    localparam logic [2:0] SANDWICH   = 3'd0;
    localparam logic [2:0] CHOCOLATE  = 3'd1;
    localparam logic [2:0] WATER      = 3'd2;
    localparam logic [2:0] COFFEE     = 3'd3;
    localparam logic [2:0] TEA        = 3'd4;
    localparam logic [2:0] INVALID_ID = 3'b111;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_INVALID      = 3'd1;
    localparam logic [2:0] ERR_UNAVAILABLE  = 3'd2;
    localparam logic [2:0] ERR_SUGAR        = 3'd3;
    localparam logic [2:0] ERR_NOT_EXACT    = 3'd4;
    localparam logic [2:0] ERR_INSUFFICIENT = 3'd5;
    localparam logic [2:0] ERR_PROTOCOL     = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        REQ,
        WAIT,
        CHANGE
    } state_t;

    function automatic logic [5:0] coin_value(input logic [1:0] c);
        return c == COIN_20 ? 6'd20 : c == COIN_10 ? 6'd10 : c == COIN_5 ? 6'd5 : 6'd1;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// change_dispenser: after a load pulse, pays out the amount as greedy coins
// (20/10/5/1), one per cycle, then pulses o_done.
module change_dispenser
    import vend_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_load,
    input  logic [5:0] i_amount,
    output logic       o_change_valid,
    output logic [1:0] o_change_coin,
    output logic       o_done,
    output logic       o_finish
);
    logic [5:0] r_rem;
    logic       r_active;
    logic       r_valid;
    logic [1:0] r_coin;
    logic       r_done;
    logic [1:0] w_coin;
    logic       w_emit;

    always_comb begin
        w_coin = r_rem >= 6'd20 ? COIN_20 : r_rem >= 6'd10 ? COIN_10 : r_rem >= 6'd5 ? COIN_5 : COIN_1;
        w_emit = r_active && r_rem != '0;
    end

    assign o_finish       = r_active && r_rem == '0;
    assign o_change_valid = r_valid;
    assign o_change_coin  = r_coin;
    assign o_done         = r_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rem    <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
            r_coin   <= COIN_1;
            r_done   <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_coin  <= w_emit ? w_coin : COIN_1;
            r_done  <= o_finish;
            if (i_load) begin
                r_rem    <= i_amount;
                r_active <= 1'b1;
            end else if (w_emit) begin
                r_rem <= r_rem - coin_value(w_coin);
            end else if (o_finish) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vend_order_ctrl.sv
// vend_order_ctrl: collects coins, issues one purchase request, decodes the status and returns change.
// Define VEND_COIN_TIMEOUT_EN to build the COLLECT idle timer that auto-refunds after COIN_TIMEOUT cycles.
module vend_order_ctrl
    import vend_pkg::*;
#(
    parameter int COIN_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       coinValid,
    input  logic [1:0] coinValue,
    input  logic       selValid,
    input  logic       selVm,
    input  logic [2:0] selProduct,
    input  logic       selSugar,
    input  logic       cancel,
    input  logic [5:0] respMoneyLeft,
    input  logic       respProductReady,
    input  logic       respProductUnavailable,
    input  logic       respInsufficientFund,
    input  logic       respNotExactFund,
    input  logic       respInvalidProduct,
    input  logic       respSugarUnsuitable,
    output logic [5:0] reqMoney,
    output logic       reqVm,
    output logic [2:0] reqProductID,
    output logic       reqSugar,
    output logic [5:0] credit,
    output logic       busy,
    output logic       coinReject,
    output logic       dispensed,
    output logic       errValid,
    output logic [2:0] errCode,
    output logic       changeValid,
    output logic [1:0] changeCoin,
    output logic       done
);
    state_t     r_state, w_state_nxt;
    logic [5:0] r_credit, w_credit_nxt;
    logic       r_vm, r_sugar;
    logic [2:0] r_product;
    logic       r_coin_reject, r_dispensed, r_err_valid;
    logic [2:0] r_err_code;
    logic       w_coin_reject, w_dispensed, w_err_valid, w_latch, w_load, w_finish, w_timeout;
    logic [2:0] w_err_code;
    logic [5:0] w_load_amt;
    logic [6:0] w_sum;

    if (COIN_TIMEOUT < 1 || COIN_TIMEOUT > 15) begin : g_bad_timeout
        $error("COIN_TIMEOUT must fit the 4-bit idle timer (1..15)");
    end

`ifdef VEND_COIN_TIMEOUT_EN
    logic [3:0] r_timer;
    assign w_timeout = r_state == COLLECT && !coinValid && !selValid && !cancel
                       && r_timer == 4'(COIN_TIMEOUT - 1);
    always_ff @(posedge CLK) begin
        if (RST || r_state != COLLECT || coinValid || selValid || cancel)
            r_timer <= '0;
        else
            r_timer <= r_timer + 4'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_credit_nxt  = r_credit;
        w_coin_reject = 1'b0;
        w_dispensed   = 1'b0;
        w_err_valid   = 1'b0;
        w_err_code    = ERR_NONE;
        w_latch       = 1'b0;
        w_load        = 1'b0;
        w_load_amt    = r_credit;
        w_sum         = {1'b0, r_credit} + {1'b0, coin_value(coinValue)};
        unique case (r_state)
            IDLE: begin
                if (coinValid) begin
                    w_credit_nxt = coin_value(coinValue);
                    w_state_nxt  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel || w_timeout) begin
                    w_coin_reject = coinValid;
                    w_load        = 1'b1;
                    w_credit_nxt  = '0;
                    w_state_nxt   = CHANGE;
                end else if (selValid) begin
                    w_coin_reject = coinValid;
                    w_latch       = 1'b1;
                    w_state_nxt   = REQ;
                end else if (coinValid) begin
                    w_coin_reject = w_sum > 7'd63;
                    w_credit_nxt  = w_sum > 7'd63 ? r_credit : w_sum[5:0];
                end
            end
            REQ: begin
                w_coin_reject = coinValid;
                w_state_nxt   = WAIT;
            end
            WAIT: begin
                // if/else chain so a flag that is not exactly 1 (including X) reads as clear
                w_coin_reject = coinValid;
                w_err_valid   = 1'b1;
                if (respInvalidProduct == 1'b1)
                    w_err_code = ERR_INVALID;
                else if (respProductUnavailable == 1'b1)
                    w_err_code = ERR_UNAVAILABLE;
                else if (respSugarUnsuitable == 1'b1)
                    w_err_code = ERR_SUGAR;
                else if (respNotExactFund == 1'b1)
                    w_err_code = ERR_NOT_EXACT;
                else if (respInsufficientFund == 1'b1)
                    w_err_code = ERR_INSUFFICIENT;
                else if (respProductReady == 1'b1) begin
                    w_err_valid = 1'b0;
                    w_dispensed = 1'b1;
                end else
                    w_err_code = ERR_PROTOCOL;
                w_load       = 1'b1;
                w_load_amt   = w_err_code == ERR_PROTOCOL ? r_credit : respMoneyLeft;
                w_credit_nxt = '0;
                w_state_nxt  = CHANGE;
            end
            CHANGE: begin
                w_coin_reject = coinValid;
                w_state_nxt   = w_finish ? IDLE : CHANGE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_vm          <= 1'b0;
            r_sugar       <= 1'b0;
            r_product     <= INVALID_ID;
            r_coin_reject <= 1'b0;
            r_dispensed   <= 1'b0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_coin_reject <= w_coin_reject;
            r_dispensed   <= w_dispensed;
            r_err_valid   <= w_err_valid;
            r_err_code    <= w_err_code;
            if (w_latch) begin
                r_vm      <= selVm;
                r_sugar   <= selSugar;
                r_product <= selProduct;
            end
        end
    end

    change_dispenser u_change (
        .CLK            (CLK),
        .RST            (RST),
        .i_load         (w_load),
        .i_amount       (w_load_amt),
        .o_change_valid (changeValid),
        .o_change_coin  (changeCoin),
        .o_done         (done),
        .o_finish       (w_finish)
    );

    // The vending unit acts every cycle, so the request is parked on an invalid ID outside REQ
    assign reqMoney     = r_state == REQ ? r_credit : '0;
    assign reqVm        = r_state == REQ && r_vm;
    assign reqSugar     = r_state == REQ && r_sugar;
    assign reqProductID = r_state == REQ ? r_product : INVALID_ID;
    assign credit       = r_credit;
    assign busy         = r_state != IDLE;
    assign coinReject   = r_coin_reject;
    assign dispensed    = r_dispensed;
    assign errValid     = r_err_valid;
    assign errCode      = r_err_code;

endmodule

// File: tb/tb_vend_order_ctrl.sv
// tb_vend_order_ctrl: directed scenarios for vend_order_ctrl, each task checking its own results.
// Honours VEND_COIN_TIMEOUT_EN to pick the expected idle-timeout behaviour.
module tb_vend_order_ctrl;
    import vend_pkg::*;

    logic       CLK, RST;
    logic       coinValid, selValid, selVm, selSugar, cancel;
    logic [1:0] coinValue;
    logic [2:0] selProduct;
    logic [5:0] respMoneyLeft;
    logic       respProductReady, respProductUnavailable, respInsufficientFund;
    logic       respNotExactFund, respInvalidProduct, respSugarUnsuitable;
    logic [5:0] reqMoney, credit;
    logic       reqVm, reqSugar, busy, coinReject, dispensed, errValid, changeValid, done;
    logic [2:0] reqProductID, errCode;
    logic [1:0] changeCoin;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] got_coins;
    int          n_coins;
    int          first_at;
    bit          done_seen;

    vend_order_ctrl #(.COIN_TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .coinValid(coinValid), .coinValue(coinValue),
        .selValid(selValid), .selVm(selVm), .selProduct(selProduct), .selSugar(selSugar),
        .cancel(cancel),
        .respMoneyLeft(respMoneyLeft), .respProductReady(respProductReady),
        .respProductUnavailable(respProductUnavailable), .respInsufficientFund(respInsufficientFund),
        .respNotExactFund(respNotExactFund), .respInvalidProduct(respInvalidProduct),
        .respSugarUnsuitable(respSugarUnsuitable),
        .reqMoney(reqMoney), .reqVm(reqVm), .reqProductID(reqProductID), .reqSugar(reqSugar),
        .credit(credit), .busy(busy), .coinReject(coinReject), .dispensed(dispensed),
        .errValid(errValid), .errCode(errCode), .changeValid(changeValid),
        .changeCoin(changeCoin), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_resp;
        respMoneyLeft          = '0;
        respProductReady       = 1'b0;
        respProductUnavailable = 1'b0;
        respInsufficientFund   = 1'b0;
        respNotExactFund       = 1'b0;
        respInvalidProduct     = 1'b0;
        respSugarUnsuitable    = 1'b0;
    endtask

    task automatic insert(input logic [1:0] c);
        coinValid = 1'b1;
        coinValue = c;
        tick();
        coinValid = 1'b0;
    endtask

    task automatic select(input logic vm, input logic [2:0] p, input logic s);
        selValid   = 1'b1;
        selVm      = vm;
        selProduct = p;
        selSugar   = s;
        tick();
        selValid = 1'b0;
    endtask

    task automatic drain_change(input int budget);
        got_coins = '0;
        n_coins   = 0;
        first_at  = -1;
        done_seen = 1'b0;
        for (int i = 1; i <= budget && !done_seen; i++) begin
            tick();
            if (changeValid) begin
                if (first_at < 0) first_at = i;
                got_coins = {got_coins[13:0], changeCoin};
                n_coins++;
            end
            if (done) done_seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        coinValid = 1'b0; coinValue = COIN_1; selValid = 1'b0; selVm = 1'b0;
        selProduct = SANDWICH; selSugar = 1'b0; cancel = 1'b0;
        clear_resp();
        tick(); tick();
        RST = 1'b0;
        checks++;
        if ({reqMoney, reqVm, reqSugar, credit, busy, coinReject, dispensed, errValid, errCode,
             changeValid, changeCoin, done} !== '0)
            begin errors++; $display("FAIL reset_zero: outputs not all zero (reqMoney=%0d credit=%0d busy=%b done=%b)", reqMoney, credit, busy, done); end
        checks++;
        if (reqProductID !== INVALID_ID)
            begin errors++; $display("FAIL reset_pid: got %0d expected 7", reqProductID); end
        selValid = 1'b1; cancel = 1'b1;
        tick();
        selValid = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || reqProductID !== INVALID_ID)
            begin errors++; $display("FAIL idle_ignore: busy=%b pid=%0d expected busy=0 pid=7", busy, reqProductID); end
    endtask

    task automatic test_sandwich;
        insert(COIN_20);
        checks++;
        if (credit !== 6'd20 || busy !== 1'b1)
            begin errors++; $display("FAIL sw_credit: credit=%0d busy=%b expected 20/1", credit, busy); end
        select(1'b0, SANDWICH, 1'b0);
        checks++;
        if (reqMoney !== 6'd20 || reqProductID !== SANDWICH || reqVm !== 1'b0 || reqSugar !== 1'b0)
            begin errors++; $display("FAIL sw_req: money=%0d pid=%0d vm=%b sugar=%b expected 20/0/0/0", reqMoney, reqProductID, reqVm, reqSugar); end
        respProductReady = 1'b1;
        tick();
        checks++;
        if (reqProductID !== INVALID_ID || reqMoney !== 6'd0)
            begin errors++; $display("FAIL sw_req_once: pid=%0d money=%0d expected 7/0", reqProductID, reqMoney); end
        tick();
        clear_resp();
        checks++;
        if (dispensed !== 1'b1 || errValid !== 1'b0)
            begin errors++; $display("FAIL sw_dispensed: dispensed=%b errValid=%b expected 1/0", dispensed, errValid); end
        drain_change(10);
        checks++;
        if (n_coins != 0 || !done_seen || first_at != -1)
            begin errors++; $display("FAIL sw_change: coins=%0d done=%b expected 0 coins and done", n_coins, done_seen); end
        checks++;
        if (busy !== 1'b0 || credit !== 6'd0 || dispensed !== 1'b0)
            begin errors++; $display("FAIL sw_idle: busy=%b credit=%0d dispensed=%b expected 0/0/0", busy, credit, dispensed); end
        tick();
    endtask

    task automatic test_coffee;
        insert(COIN_10); insert(COIN_10);
        select(1'b1, COFFEE, 1'b1);
        checks++;
        if (reqMoney !== 6'd20 || reqProductID !== COFFEE || reqVm !== 1'b1 || reqSugar !== 1'b1)
            begin errors++; $display("FAIL cof_req: money=%0d pid=%0d vm=%b sugar=%b expected 20/3/1/1", reqMoney, reqProductID, reqVm, reqSugar); end
        respProductReady = 1'b1;
        respMoneyLeft    = 6'd8;
        insert(COIN_1);
        checks++;
        if (coinReject !== 1'b1 || credit !== 6'd20)
            begin errors++; $display("FAIL cof_busy_reject: coinReject=%b credit=%0d expected 1/20", coinReject, credit); end
        tick();
        clear_resp();
        checks++;
        if (dispensed !== 1'b1 || coinReject !== 1'b0)
            begin errors++; $display("FAIL cof_dispensed: dispensed=%b coinReject=%b expected 1/0", dispensed, coinReject); end
        drain_change(12);
        checks++;
        if (n_coins != 4 || got_coins !== 16'({COIN_5, COIN_1, COIN_1, COIN_1}) || !done_seen || first_at != 1)
            begin errors++; $display("FAIL cof_change: n=%0d coins=%h first=%0d done=%b expected 4 coins 5,1,1,1 first=1", n_coins, got_coins, first_at, done_seen); end
        tick();
    endtask

    task automatic test_not_exact;
        insert(COIN_5); insert(COIN_5); insert(COIN_1);
        checks++;
        if (credit !== 6'd11)
            begin errors++; $display("FAIL ne_credit: credit=%0d expected 11", credit); end
        select(1'b0, CHOCOLATE, 1'b0);
        respMoneyLeft        = 6'd11;
        respNotExactFund     = 1'b1;
        respInsufficientFund = 1'bx;
        respProductReady     = 1'bx;
        tick(); tick();
        clear_resp();
        checks++;
        if (errValid !== 1'b1 || errCode !== ERR_NOT_EXACT || dispensed !== 1'b0)
            begin errors++; $display("FAIL ne_err: errValid=%b errCode=%0d dispensed=%b expected 1/4/0", errValid, errCode, dispensed); end
        drain_change(10);
        checks++;
        if (n_coins != 2 || got_coins !== 16'({COIN_10, COIN_1}) || !done_seen)
            begin errors++; $display("FAIL ne_change: n=%0d coins=%h done=%b expected 10,1", n_coins, got_coins, done_seen); end
        tick();
    endtask

    task automatic test_protocol;
        insert(COIN_5);
        select(1'b0, TEA, 1'b0);
        respMoneyLeft = 6'd9;
        tick(); tick();
        clear_resp();
        checks++;
        if (errValid !== 1'b1 || errCode !== ERR_PROTOCOL)
            begin errors++; $display("FAIL proto_err: errValid=%b errCode=%0d expected 1/6", errValid, errCode); end
        drain_change(10);
        checks++;
        if (n_coins != 1 || got_coins !== 16'(COIN_5) || !done_seen)
            begin errors++; $display("FAIL proto_change: n=%0d coins=%h done=%b expected single 5", n_coins, got_coins, done_seen); end
        tick();
    endtask

    task automatic test_overflow;
        insert(COIN_20); insert(COIN_20); insert(COIN_20);
        insert(COIN_20);
        checks++;
        if (coinReject !== 1'b1 || credit !== 6'd60)
            begin errors++; $display("FAIL ovf_reject: coinReject=%b credit=%0d expected 1/60", coinReject, credit); end
        tick();
        checks++;
        if (coinReject !== 1'b0 || credit !== 6'd60)
            begin errors++; $display("FAIL ovf_pulse: coinReject=%b credit=%0d expected 0/60", coinReject, credit); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        drain_change(12);
        checks++;
        if (n_coins != 3 || got_coins !== 16'({COIN_20, COIN_20, COIN_20}) || !done_seen)
            begin errors++; $display("FAIL ovf_refund: n=%0d coins=%h done=%b expected 20,20,20", n_coins, got_coins, done_seen); end
        tick();
    endtask

    task automatic test_timeout;
        insert(COIN_5); insert(COIN_1); insert(COIN_1);
        checks++;
        if (credit !== 6'd7)
            begin errors++; $display("FAIL to_credit: credit=%0d expected 7", credit); end
`ifdef VEND_COIN_TIMEOUT_EN
        drain_change(40);
        checks++;
        if (first_at < 15 || first_at > 17)
            begin errors++; $display("FAIL to_delay: first coin after %0d cycles expected 15..17", first_at); end
        checks++;
        if (n_coins != 3 || got_coins !== 16'({COIN_5, COIN_1, COIN_1}) || !done_seen)
            begin errors++; $display("FAIL to_refund: n=%0d coins=%h done=%b expected 5,1,1", n_coins, got_coins, done_seen); end
`else
        drain_change(100);
        checks++;
        if (n_coins != 0 || busy !== 1'b1 || credit !== 6'd7)
            begin errors++; $display("FAIL to_none: n=%0d busy=%b credit=%0d expected 0/1/7", n_coins, busy, credit); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        drain_change(10);
        checks++;
        if (n_coins != 3 || got_coins !== 16'({COIN_5, COIN_1, COIN_1}) || !done_seen)
            begin errors++; $display("FAIL to_cancel: n=%0d coins=%h done=%b expected 5,1,1", n_coins, got_coins, done_seen); end
`endif
        tick();
    endtask

    task automatic test_reset_mid;
        int extra;
        insert(COIN_20); insert(COIN_20); insert(COIN_5);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 5 && changeValid !== 1'b1; i++) tick();
        checks++;
        if (changeValid !== 1'b1 || changeCoin !== COIN_20)
            begin errors++; $display("FAIL rst_first: changeValid=%b coin=%0d expected 1/3", changeValid, changeCoin); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({reqMoney, reqVm, reqSugar, credit, busy, coinReject, dispensed, errValid, errCode,
             changeValid, changeCoin, done} !== '0 || reqProductID !== INVALID_ID)
            begin errors++; $display("FAIL rst_outputs: changeValid=%b busy=%b credit=%0d pid=%0d expected reset values", changeValid, busy, credit, reqProductID); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (changeValid || done) extra++;
        end
        checks++;
        if (extra != 0)
            begin errors++; $display("FAIL rst_quiet: %0d pulses after reset expected 0", extra); end
    endtask

    initial begin
        test_reset();
        test_sandwich();
        test_coffee();
        test_not_exact();
        test_protocol();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
